// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants and types for the scanned 7-segment display decoder.
// Segment codes are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_SLOT3 = 4'b0111;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_IDLE  = 4'b1111;

    typedef enum logic [1:0] {
        SYNC,
        EXP2,
        EXP1,
        EXP0
    } state_t;

endpackage

// File: rtl/seg_scan_decoder_seg_to_bcd.sv
// Maps one active-low segment pattern to {legal, blank, bcd}.
// Blank reports bcd 0; unknown patterns clear legal.
module seg_to_bcd
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] bcd
);

    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        bcd   = 4'd0;
        unique case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four digits shown on a multiplexed 7-segment display by
// debouncing each anode dwell and assembling slot3..slot0 into frames.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  blinking,
    output logic        frame_valid,
    output logic        err
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int CW = $clog2(BLINK_FRAMES + 1);

    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic [SW-1:0] stab_cnt;
    logic          armed;
    logic          accept;

    state_t state, state_nxt;

    logic          single, idle;
    logic [1:0]    slot, exp_slot;
    logic          legal, seg_blank;
    logic [3:0]    seg_bcd;
    logic          evt, bad, hit;
    logic          store, complete, set_err;

    logic [15:0]   sh_digits, frame_digits;
    logic [3:0]    sh_blank, frame_blank;
    logic [CW-1:0] blink_cnt [4];

    assign accept = armed && (stab_cnt == SW'(STABLE_CYCLES));

    // Any change restarts the dwell and re-arms the single accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q     <= AN_IDLE;
            seg_q    <= SEG_BLANK;
            stab_cnt <= '0;
            armed    <= 1'b1;
        end else if ({an, seg} != {an_q, seg_q}) begin
            an_q     <= an;
            seg_q    <= seg;
            stab_cnt <= SW'(1);
            armed    <= 1'b1;
        end else begin
            if (stab_cnt != SW'(STABLE_CYCLES))
                stab_cnt <= stab_cnt + 1'b1;
            if (accept)
                armed <= 1'b0;
        end
    end

    always_comb begin
        single = 1'b1;
        slot   = 2'd0;
        unique case (1'b1)
            (an_q == AN_SLOT3): slot = 2'd3;
            (an_q == AN_SLOT2): slot = 2'd2;
            (an_q == AN_SLOT1): slot = 2'd1;
            (an_q == AN_SLOT0): slot = 2'd0;
            default:            single = 1'b0;
        endcase
    end

    assign idle = (an_q == AN_IDLE);

    seg_to_bcd u_seg_to_bcd (
        .seg   (seg_q),
        .legal (legal),
        .blank (seg_blank),
        .bcd   (seg_bcd)
    );

    always_comb begin
        exp_slot = 2'd3;
        unique case (state)
            SYNC: exp_slot = 2'd3;
            EXP2: exp_slot = 2'd2;
            EXP1: exp_slot = 2'd1;
            EXP0: exp_slot = 2'd0;
        endcase
    end

    assign evt = accept && single && legal;
    assign bad = accept && !idle && !(single && legal);
    assign hit = evt && (slot == exp_slot);

    always_ff @(posedge clk) begin
        if (rst)
            state <= SYNC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bad) begin
            state_nxt = SYNC;
        end else if (hit) begin
            unique case (state)
                SYNC: state_nxt = EXP2;
                EXP2: state_nxt = EXP1;
                EXP1: state_nxt = EXP0;
                EXP0: state_nxt = SYNC;
            endcase
        end else if (evt && state != SYNC) begin
            state_nxt = (slot == 2'd3) ? EXP2 : SYNC;
        end
    end

    always_comb begin
        store    = evt && (hit || slot == 2'd3);
        complete = hit && (state == EXP0);
        set_err  = bad || (evt && !hit && state != SYNC);
    end

    // Slot0 lands in the same cycle the frame completes.
    assign frame_digits = {sh_digits[15:4], seg_bcd};
    assign frame_blank  = {sh_blank[3:1], seg_blank};

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_digits   <= '0;
            sh_blank    <= '0;
            digits      <= '0;
            blank       <= 4'hF;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_valid <= complete;
            if (set_err)
                err <= 1'b1;
            if (store) begin
                sh_digits[{slot, 2'b00} +: 4] <= seg_bcd;
                sh_blank[slot]                <= seg_blank;
            end
            if (complete) begin
                digits <= frame_digits;
                blank  <= frame_blank;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rst)
                blink_cnt[n] <= '0;
            else if (complete) begin
                if (frame_blank[n] != blank[n])
                    blink_cnt[n] <= CW'(BLINK_FRAMES);
                else if (blink_cnt[n] != '0)
                    blink_cnt[n] <= blink_cnt[n] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++)
            blinking[n] = (blink_cnt[n] != '0);
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an  = 4'hF;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  blinking;
    logic        frame_valid;
    logic        err;

    int total  = 0;
    int bad    = 0;
    int fv_cnt = 0;
    int fv0    = 0;

    seg_scan_decoder #(
        .STABLE_CYCLES (4),
        .BLINK_FRAMES  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .blank       (blank),
        .blinking    (blinking),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (frame_valid)
            fv_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s,
                         input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] s3, input logic [6:0] s2,
                         input logic [6:0] s1, input logic [6:0] s0);
        dwell(4'b0111, s3, 6);
        dwell(4'b1011, s2, 6);
        dwell(4'b1101, s1, 6);
        dwell(4'b1110, s0, 6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h7F;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_digits", digits, 16'h0000);
        chk("rst_blank", blank, 4'hF);
        chk("rst_blinking", blinking, 4'h0);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;

        // 1:2:3:4 with 6-cycle dwells
        fv0 = fv_cnt;
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        chk("1234_fv", fv_cnt - fv0, 2);
        chk("1234_digits", digits, 16'h1234);
        chk("1234_blank", blank, 4'h0);
        chk("1234_err", err, 1'b0);
        chk("1234_blinking", blinking, 4'hF);

        // 3-cycle dwells never accepted
        fv0 = fv_cnt;
        repeat (2) begin
            dwell(4'b0111, 7'h40, 3);
            dwell(4'b1011, 7'h12, 3);
            dwell(4'b1101, 7'h10, 3);
            dwell(4'b1110, 7'h00, 3);
        end
        chk("short_fv", fv_cnt - fv0, 0);
        chk("short_err", err, 1'b0);
        chk("short_digits", digits, 16'h1234);

        // slot3 then slot1 is out of order
        fv0 = fv_cnt;
        dwell(4'b0111, 7'h79, 6);
        dwell(4'b1101, 7'h30, 6);
        chk("order_err", err, 1'b1);
        chk("order_fv", fv_cnt - fv0, 0);
        chk("order_digits", digits, 16'h1234);
        frame(7'h40, 7'h12, 7'h10, 7'h00);
        chk("0598_fv", fv_cnt - fv0, 1);
        chk("0598_digits", digits, 16'h0598);
        chk("0598_err", err, 1'b1);

        // blink behaviour
        do_reset();
        repeat (9) frame(7'h79, 7'h24, 7'h30, 7'h19);
        chk("settle_blinking", blinking, 4'h0);
        frame(7'h7F, 7'h7F, 7'h30, 7'h19);
        chk("blk_blank", blank, 4'b1100);
        chk("blk_digits", digits, 16'h0034);
        chk("blk_blinking", blinking, 4'b1100);
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        frame(7'h7F, 7'h7F, 7'h30, 7'h19);
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        chk("alt_blinking", blinking, 4'b1100);
        chk("alt_blank", blank, 4'h0);
        repeat (7) frame(7'h79, 7'h24, 7'h30, 7'h19);
        chk("blink_7", blinking, 4'b1100);
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        chk("blink_8", blinking, 4'h0);
        chk("blink_err", err, 1'b0);

        // illegal pattern on slot1
        do_reset();
        fv0 = fv_cnt;
        dwell(4'b0111, 7'h79, 6);
        dwell(4'b1011, 7'h24, 6);
        dwell(4'b1101, 7'h7E, 6);
        dwell(4'b1110, 7'h19, 6);
        chk("illegal_err", err, 1'b1);
        chk("illegal_fv", fv_cnt - fv0, 0);
        chk("illegal_digits", digits, 16'h0000);

        // idle anodes with garbage segments are ignored
        do_reset();
        dwell(4'hF, 7'h7E, 10);
        chk("idle_err", err, 1'b0);

        // two anodes low
        dwell(4'b0011, 7'h40, 6);
        chk("multi_an_err", err, 1'b1);

        // reset mid-frame
        do_reset();
        frame(7'h79, 7'h24, 7'h30, 7'h19);
        chk("pre_rst_digits", digits, 16'h1234);
        dwell(4'b0111, 7'h40, 6);
        dwell(4'b1011, 7'h12, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_digits", digits, 16'h0000);
        chk("mid_rst_blank", blank, 4'hF);
        chk("mid_rst_blinking", blinking, 4'h0);
        chk("mid_rst_fv", frame_valid, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        fv0 = fv_cnt;
        dwell(4'b1101, 7'h10, 6);
        dwell(4'b1110, 7'h00, 6);
        chk("partial_fv", fv_cnt - fv0, 0);
        chk("partial_digits", digits, 16'h0000);
        frame(7'h40, 7'h12, 7'h10, 7'h00);
        chk("full_fv", fv_cnt - fv0, 1);
        chk("full_digits", digits, 16'h0598);
        chk("full_err", err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the number of consecutive identical clock samples required before a slot is accepted.
REQ-002 SHALL have parameter BLINK_FRAMES, default 8, giving the number of frames a slot stays flagged as blinking after its last lit/blank toggle.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 seg  in  7  active-low segments {g,f,e,d,c,b,a}, driven by the scanned display.
REQ-006 an  in  4  active-low anodes: 0111=slot3 (min tens), 1011=slot2, 1101=slot1, 1110=slot0 (sec ones).
REQ-007 digits  out  16  captured BCD {slot3,slot2,slot1,slot0}, 4 bits each.
REQ-008 blank  out  4  per slot, 1 = slot was all segments off (7'h7F) in the last frame.
REQ-009 blinking  out  4  per slot, 1 = slot toggled lit/blank within the last BLINK_FRAMES frames.
REQ-010 frame_valid  out  1  one-cycle pulse when digits/blank update.
REQ-011 err  out  1  sticky error flag; cleared only by rst.

Function
REQ-012 Decoding SHALL use 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F (hex), with every other pattern treated as illegal.
REQ-013 The block SHALL register {an,seg} once and count consecutive cycles in which the registered value is unchanged.
REQ-014 A slot SHALL be accepted exactly once per dwell, on the cycle its stable count reaches STABLE_CYCLES; a value change restarts the count and re-arms acceptance.
REQ-015 A stable an=1111 SHALL be treated as idle: ignored, no error, FSM state unchanged.
REQ-016 Any other stable an value with more than one zero SHALL set err and return the FSM to SYNC.
REQ-017 The FSM SHALL have states SYNC, EXP2, EXP1, EXP0.
REQ-018 SYNC SHALL wait for an accepted slot3; on it, store to shadow and go to EXP2.
REQ-019 EXPn SHALL, on accepted slot n, store to shadow and advance (EXP2 to EXP1 to EXP0).
REQ-020 EXP0 SHALL, on accepted slot0, complete the frame and go to EXP2 only if the next accept is slot3; otherwise it SHALL go to SYNC.
REQ-021 On frame completion, digits/blank SHALL load from shadow atomically, and frame_valid SHALL pulse in the same cycle as that load, one cycle after the slot0 accept.
REQ-022 An out-of-order accepted slot in any EXPn state SHALL set err, discard the shadow, and move to EXP2 if the slot is slot3, else to SYNC.
REQ-023 An illegal seg pattern on an accepted slot SHALL set err, abort the frame, and move to SYNC.
REQ-024 Per slot, a blank bit differing from the previous frame's value SHALL load that slot's frame counter with BLINK_FRAMES; otherwise the counter SHALL decrement per completed frame, saturating at 0.
REQ-025 blinking[n] SHALL equal (counter[n] != 0).
REQ-026 The counter width SHALL be $clog2(BLINK_FRAMES+1).
REQ-027 Blank slots SHALL report digit 0 in digits.
REQ-028 Outputs SHALL change only on frame completion (except err), so partial frames never appear on the outputs.

Reset
REQ-029 On rst, the block SHALL set digits=0, blank=4'hF, blinking=0, frame_valid=0, err=0, FSM=SYNC, stable count=0, acceptance armed, and blink counters=0.
REQ-030 Reset asserted mid-frame SHALL discard the shadow; the first frame_valid after release SHALL require a full new slot3..slot0 sequence.

Structure
REQ-031 A shared package SHALL hold the seg code constants (SEG_0..SEG_9, SEG_BLANK), the anode slot constants, and the FSM state enum.
REQ-032 A single combinational sub-module seg_to_bcd SHALL map a 7-bit pattern to {legal, blank, bcd[3:0]}; all sequencing stays in seg_scan_decoder.

Verification
REQ-033 Scanning 1:2:3:4 (slot3..0 = 79,24,30,19), 6 cycles per slot, SHALL give frame_valid pulses, digits=16'h1234, blank=0, and err=0.
REQ-034 A slot dwell of 3 cycles with STABLE_CYCLES=4 SHALL produce no frame_valid and no err.
REQ-035 Scan order slot3, slot1 SHALL set err, produce no frame_valid, and leave digits unchanged; a following clean frame 0:5:9:8 SHALL yield 16'h0598 with err still 1.
REQ-036 Slots 3 and 2 alternating 7F/lit on successive frames SHALL give blinking=4'b1100; after they stop toggling, blinking SHALL clear after exactly 8 frames.
REQ-037 seg=7'h7E on slot1 SHALL set err and abort the frame; an=0011 stable SHALL set err.
REQ-038 rst pulsed after slot2 is accepted SHALL produce reset values next cycle, and the next frame_valid SHALL occur only after a full slot3..slot0 sequence.
